// File: rtl/i2s_rx_ctrl.sv
// I2S receive master sequencer: bck/lrck generation, deserializer strobes,
// and left/right packing into stereo frames on a valid/ready output.
module i2s_rx_ctrl #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int DIV_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      clk_div,
  input  logic                  clr_ovr,
  input  logic [DATA_W-1:0]     rx_word,
  output logic                  bck,
  output logic                  lrck,
  output logic                  shift_en,
  output logic                  word_done,
  output logic                  word_ch,
  output logic [2*DATA_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  busy
);

  // state | meaning
  // IDLE  | generator parked, bck/lrck held low, waiting for enable
  // RUN   | generating bck/lrck and strobes, packing frames
  // STOP  | enable dropped; keep running until the right slot ends
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

  localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_W - 1);
  localparam logic [BW-1:0] BIT_DATA = BW'(DATA_W);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_lat;
  logic [DIV_W-1:0]  div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] left_hold;
  logic              have_left;

  logic tc, bck_rise, bck_fall, frame_end;
  logic start, stop_done;
  logic wd_left, wd_right, can_load;

  assign tc        = (div_cnt == div_lat);
  assign bck_rise  = tc && !bck;
  assign bck_fall  = tc && bck;
  assign frame_end = bck_fall && (bit_cnt == BIT_LAST) && lrck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable)    state_nxt = ST_RUN;
      ST_RUN:  if (!enable)   state_nxt = ST_STOP;
      ST_STOP: if (frame_end) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    start     = (state == ST_IDLE) && enable;
    stop_done = (state == ST_STOP) && frame_end;
  end

  // Divider, bit counter and strobe generation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_lat   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      bck       <= 1'b0;
      lrck      <= 1'b0;
      shift_en  <= 1'b0;
      word_done <= 1'b0;
      word_ch   <= 1'b0;
    end else if (state == ST_IDLE || stop_done) begin
      if (start) div_lat <= clk_div;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      bck       <= 1'b0;
      lrck      <= 1'b0;
      shift_en  <= 1'b0;
      word_done <= 1'b0;
      word_ch   <= 1'b0;
    end else begin
      // One-bit I2S delay: the MSB arrives on the rise after the slot's first fall.
      shift_en  <= bck_rise && (bit_cnt >= BW'(1)) && (bit_cnt <= BIT_DATA);
      word_done <= bck_fall && (bit_cnt == BIT_DATA);
      word_ch   <= bck_fall && (bit_cnt == BIT_DATA) && lrck;
      if (tc) begin
        div_cnt <= '0;
        bck     <= ~bck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (bck_fall) begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          lrck    <= ~lrck;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  assign wd_left  = word_done && !word_ch;
  assign wd_right = word_done && word_ch && have_left;
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_hold <= '0;
      have_left <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start) begin
        have_left <= 1'b0;
      end else if (wd_left) begin
        left_hold <= rx_word;
        have_left <= 1'b1;
      end else if (wd_right) begin
        have_left <= 1'b0;
      end

      if (wd_right && can_load) begin
        out_data  <= {left_hold, rx_word};
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // A drop in the same cycle as clr_ovr keeps overrun set.
      if (wd_right && !can_load) overrun <= 1'b1;
      else if (clr_ovr)          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: an arithmetic timing/packing model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_i2s_rx_ctrl;

  localparam int D = 24;
  localparam int S = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [7:0]    clk_div;
  logic          clr_ovr;
  logic [D-1:0]  rx_word;
  logic          bck, lrck, shift_en, word_done, word_ch;
  logic [2*D-1:0] out_data;
  logic          out_valid, out_ready, overrun, busy;

  i2s_rx_ctrl #(.DATA_W(D), .SLOT_W(S), .DIV_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clk_div(clk_div),
    .clr_ovr(clr_ovr), .rx_word(rx_word), .bck(bck), .lrck(lrck),
    .shift_en(shift_en), .word_done(word_done), .word_ch(word_ch),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Behavioural model: outputs derived from time elapsed since RUN entry.
  int         m_busy, m_stop, m_t, m_h, m_hl, m_ov, m_ovr;
  logic [D-1:0]   m_lh;
  logic [2*D-1:0] m_od;
  int         m_bck, m_lrck, m_sh, m_wd, m_wch, m_bit;

  task automatic derive();
    int q, f;
    if (m_busy == 0) begin
      m_bck = 0; m_lrck = 0; m_sh = 0; m_wd = 0; m_wch = 0; m_bit = 0;
    end else begin
      q = m_t / m_h;
      f = m_t / (2 * m_h);
      m_bit  = f % S;
      m_bck  = q % 2;
      m_lrck = (f / S) % 2;
      m_sh   = (m_t > 0 && m_t % m_h == 0 && q % 2 == 1 && m_bit >= 1 && m_bit <= D) ? 1 : 0;
      m_wd   = (f > 0 && m_t % (2 * m_h) == 0 && (f - 1) % S == D) ? 1 : 0;
      m_wch  = (m_wd == 1 && ((f - 1) / S) % 2 == 1) ? 1 : 0;
    end
  endtask

  always @(posedge clk) begin
    int nt;
    if (!reset_n) begin
      m_busy = 0; m_stop = 0; m_t = 0; m_h = 1; m_hl = 0;
      m_ov = 0; m_ovr = 0; m_lh = '0; m_od = '0;
    end else begin
      if (m_wd == 1 && m_wch == 0) begin
        m_lh = rx_word; m_hl = 1;
      end else if (m_wd == 1 && m_hl == 1) begin
        m_hl = 0;
        if (m_ov == 0 || out_ready) begin
          m_od = {m_lh, rx_word}; m_ov = 1;
        end else begin
          m_ovr = 1;
        end
      end else begin
        if (m_ov == 1 && out_ready) m_ov = 0;
        if (clr_ovr) m_ovr = 0;
      end
      if (m_wd == 1 && m_wch == 1 && m_ov == 1 && !out_ready && clr_ovr) m_ovr = 1;
      if (m_wd == 1 && m_wch == 1 && m_ovr == 0 && clr_ovr) m_ovr = 0;
      if (m_busy == 0) begin
        if (enable) begin
          m_busy = 1; m_stop = 0; m_t = 0; m_h = int'(clk_div) + 1; m_hl = 0;
        end
      end else begin
        nt = m_t + 1;
        if (m_stop == 1 && nt % (2 * m_h) == 0 && (nt / (2 * m_h)) % (2 * S) == 0) begin
          m_busy = 0; m_t = 0;
        end else begin
          m_t = nt;
          if (!enable) m_stop = 1;
        end
      end
    end
    derive();
  end

  // Deserializer stand-in: fixed L/R patterns or random data.
  logic rx_fixed;
  always @(negedge clk) rx_word = rx_fixed ? ((m_wch == 1) ? 24'h5A5A5A : 24'hA5A5A5) : D'($urandom);

  // Per-cycle comparison plus waveform measurements.
  logic bck_prev = 0, lr_prev = 0;
  int last_rise = 0, bck_period = 0, lr_rise = 0, lrck_period = 0;
  int shcnt = 0, slot_shifts = 0, vrun = 0, valid_len = 0, xfer_cnt = 0;
  logic [2*D-1:0] last_od = '0;

  always @(negedge clk) begin
    chk("bck", 64'(bck), 64'(m_bck));
    chk("lrck", 64'(lrck), 64'(m_lrck));
    chk("shift_en", 64'(shift_en), 64'(m_sh));
    chk("word_done", 64'(word_done), 64'(m_wd));
    chk("word_ch", 64'(word_ch), 64'(m_wch));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_data", 64'(out_data), 64'(m_od));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("busy", 64'(busy), 64'(m_busy));
    if (bck && !bck_prev) begin bck_period = cyc - last_rise; last_rise = cyc; end
    if (lrck && !lr_prev) begin lrck_period = cyc - lr_rise; lr_rise = cyc; end
    if (shift_en) shcnt++;
    if (lrck != lr_prev) begin slot_shifts = shcnt; shcnt = 0; end
    if (out_valid) begin vrun++; last_od = out_data; end
    else if (vrun > 0) begin valid_len = vrun; vrun = 0; end
    if (out_valid && out_ready) xfer_cnt++;
    bck_prev = bck; lr_prev = lrck;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_slot(input int lr, input int b, input int budget, input string nm);
    int k = 0;
    while (!(m_busy == 1 && m_lrck == lr && m_bit == b) && k < budget) begin tick(1); k++; end
    if (k >= budget) begin n_chk++; n_err++; $display("FAIL %s: timeout after %0d cycles", nm, k); end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin tick(1); k++; end
    if (k >= budget) begin n_chk++; n_err++; $display("FAIL %s: busy still %b after %0d cycles", nm, busy, k); end
  endtask

  initial begin
    int x0;
    reset_n = 0; enable = 0; clk_div = 8'd1; clr_ovr = 0; out_ready = 1; rx_fixed = 1;
    tick(3);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_bck", 64'(bck), 0);
    chk("rst_lrck", 64'(lrck), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_overrun", 64'(overrun), 0);
    reset_n = 1;
    tick(2);

    // Basic timing and fixed-pattern frames
    enable = 1;
    tick(900);
    chk("bck_period_div1", 64'(bck_period), 4);
    chk("lrck_period", 64'(lrck_period), 256);
    chk("shifts_per_slot", 64'(slot_shifts), 24);
    chk("frame_data", 64'(last_od), 64'h0000_A5A5A5_5A5A5A);
    chk("valid_len", 64'(valid_len), 1);

    // Back-pressure and overrun
    wait_slot(0, 0, 600, "ovr_align");
    out_ready = 0;
    tick(3 * 256 + 20);
    chk("overrun_set", 64'(overrun), 1);
    chk("held_valid", 64'(out_valid), 1);
    chk("held_data", 64'(out_data), 64'h0000_A5A5A5_5A5A5A);
    wait_slot(1, 27, 600, "clr_align");
    clr_ovr = 1;
    tick(1);
    clr_ovr = 0;
    chk("overrun_clr", 64'(overrun), 0);
    out_ready = 1;
    tick(4);

    // Frame-aligned stop with enable re-asserted during STOP
    wait_slot(0, 5, 600, "stop_align");
    x0 = xfer_cnt;
    enable = 0;
    tick(20);
    enable = 1;
    wait_idle(600, "stop_idle");
    chk("stop_frames", 64'(xfer_cnt - x0), 1);
    chk("stop_lrck", 64'(lrck), 0);
    tick(1);
    chk("restart_busy", 64'(busy), 1);
    chk("restart_lrck", 64'(lrck), 0);

    // Reset mid-right slot with a frame pending
    rx_fixed = 0;
    out_ready = 0;
    wait_slot(1, 10, 600, "rst_align");
    reset_n = 0;
    #1;
    chk("midrst_bck", 64'(bck), 0);
    chk("midrst_lrck", 64'(lrck), 0);
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    enable = 0;
    tick(3);
    reset_n = 1;
    out_ready = 1;
    tick(5);
    chk("midrst_no_frame", 64'(out_valid), 0);

    // Divider extremes; clk_div changes while busy are ignored
    clk_div = 8'd0;
    enable = 1;
    tick(300);
    chk("bck_period_div0", 64'(bck_period), 2);
    clk_div = 8'd255;
    tick(200);
    chk("bck_period_locked", 64'(bck_period), 2);
    enable = 0;
    wait_idle(300, "div0_idle");
    tick(2);
    enable = 1;
    tick(1600);
    chk("bck_period_div255", 64'(bck_period), 512);
    reset_n = 0;
    enable = 0;
    tick(2);
    reset_n = 1;
    tick(2);

    // Randomized traffic
    for (int s = 0; s < 24; s++) begin
      clk_div = 8'($urandom_range(0, 3));
      enable = 1;
      for (int c = 0; c < 700; c++) begin
        out_ready = ($urandom % 4) != 0;
        clr_ovr = ($urandom % 64) == 0;
        if ($urandom % 300 == 0) enable = ~enable;
        if (c == 350) clk_div = 8'($urandom);
        tick(1);
      end
      clr_ovr = 0;
      if (s % 6 == 5) begin
        reset_n = 0;
        tick(2);
        reset_n = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
